hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 119 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight destinations and tnew per stage,
// and produces data/HI-LO stalls, forward selects and a stall counter.
module hazard_scoreboard #(
    parameter int STAGES   = 3,
    parameter int TW       = 4,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int SW       = $clog2(STAGES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dec_valid,
    input  logic [4:0]    rs_addr,
    input  logic [4:0]    rt_addr,
    input  logic [TW-1:0] rs_tuse,
    input  logic [TW-1:0] rt_tuse,
    input  logic [4:0]    dec_waddr,
    input  logic [TW-1:0] dec_tnew,
    input  logic          dec_uses_md,
    input  logic          md_start,
    input  logic          md_is_div,
    output logic          stall,
    output logic [SW-1:0] fwd_sel_rs,
    output logic [SW-1:0] fwd_sel_rt,
    output logic          md_busy,
    output logic [31:0]   stall_cycles
);

    localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int MDW    = $clog2(MD_MAX + 1);

    logic [4:0]    waddr_q [STAGES];
    logic [TW-1:0] tnew_q  [STAGES];
    logic [MDW-1:0] md_cnt_q;

    logic          rs_hit;
    logic          rt_hit;
    logic [TW-1:0] rs_tn;
    logic [TW-1:0] rt_tn;
    logic [SW-1:0] rs_sel;
    logic [SW-1:0] rt_sel;
    logic          data_stall;
    logic          md_stall;
    logic          issue;

    // Youngest-match search: scan oldest to youngest so the lowest index wins.
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        rs_tn  = '0;
        rt_tn  = '0;
        rs_sel = '0;
        rt_sel = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (rs_addr != 5'd0 && waddr_q[i] == rs_addr) begin
                rs_hit = 1'b1;
                rs_tn  = tnew_q[i];
                rs_sel = SW'(i + 1);
            end
            if (rt_addr != 5'd0 && waddr_q[i] == rt_addr) begin
                rt_hit = 1'b1;
                rt_tn  = tnew_q[i];
                rt_sel = SW'(i + 1);
            end
        end
    end

    // Stall and forward decisions; everything is forced quiet during reset.
    always_comb begin
        data_stall = dec_valid &&
                     ((rs_hit && rs_tuse < rs_tn) ||
                      (rt_hit && rt_tuse < rt_tn));
        md_stall   = dec_valid && dec_uses_md && (md_cnt_q != '0);
        stall      = !reset && (data_stall || md_stall);
        md_busy    = !reset && (md_cnt_q != '0);
        fwd_sel_rs = (!reset && rs_hit && rs_tn == '0) ? rs_sel : '0;
        fwd_sel_rt = (!reset && rt_hit && rt_tn == '0) ? rt_sel : '0;
        issue      = dec_valid && !stall;
    end

    // Pipeline shadow: insert decode or bubble, age older entries toward zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                waddr_q[i] <= '0;
                tnew_q[i]  <= '0;
            end
        end else begin
            waddr_q[0] <= issue ? dec_waddr : 5'd0;
            tnew_q[0]  <= issue ? dec_tnew : '0;
            for (int i = 1; i < STAGES; i++) begin
                waddr_q[i] <= waddr_q[i-1];
                tnew_q[i]  <= (tnew_q[i-1] != '0) ?
                              tnew_q[i-1] - TW'(1) : '0;
            end
        end
    end

    // HI/LO unit occupancy: load on an issued mult/div, else count down.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q <= '0;
        end else if (md_start && issue) begin
            md_cnt_q <= md_is_div ? MDW'(DIV_CYC) : MDW'(MULT_CYC);
        end else if (md_cnt_q != '0) begin
            md_cnt_q <= md_cnt_q - MDW'(1);
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule
